branch_history_update: RTL
==========================

BRANCH_HISTORY_UPDATE -- requirements
Module: branch_history_update

Interface
REQ-001 The block SHALL have one parameter: IDX_W, default 6, log2 of the table entry count (64 entries).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rstn  input  1  reset; asynchronous, active-low.
REQ-004 fetch_pc  input  32  PC of the instruction in fetch.
REQ-005 predict  output  1  predicted direction for fetch_pc: 1 = taken.
REQ-006 ex_valid  input  1  a resolved control-flow instruction is in EX this cycle.
REQ-007 ex_is_cond  input  1  the EX instruction is a conditional branch; 0 = unconditional jump.
REQ-008 ex_pc  input  32  PC of the EX instruction.
REQ-009 ex_pred_pc  input  32  next-PC that fetch used for the EX instruction, carried down the pipeline.
REQ-010 ex_taken  input  1  actual direction; ignored when ex_is_cond=0, where it is treated as 1.
REQ-011 ex_target  input  32  actual taken target.
REQ-012 redirect  output  1  registered pulse: fetch must restart at redirect_pc.
REQ-013 redirect_pc  output  32  registered correct next-PC.
REQ-014 branch_cnt  output  32  count of accepted conditional-branch resolutions.
REQ-015 mispredict_cnt  output  32  count of issued redirects.

Function
REQ-016 The table SHALL hold 2^IDX_W two-bit saturating counters with encoding 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
REQ-017 The table SHALL be indexed by pc[IDX_W+1:2], with no tag.
REQ-018 predict SHALL be combinational and equal bit 1 of counter[fetch_pc index].
REQ-019 The block SHALL not bypass same-cycle updates: a same-index read and update in one cycle returns the pre-update value.
REQ-020 An accepted resolution is ex_valid=1 and redirect=0; while redirect=1, EX contents are wrong-path and SHALL be ignored entirely (no update, no count, no redirect).
REQ-021 The actual next-PC SHALL be: (ex_is_cond ? ex_taken : 1) ? ex_target : ex_pc+4, computed with 32-bit wrap-around.
REQ-022 On an accepted resolution with ex_is_cond=1, the indexed counter SHALL update at the next edge:
- taken: +1, saturating at 11.
- not taken: -1, saturating at 00.
REQ-023 On an accepted resolution with ex_is_cond=0, the block SHALL not modify any counter.
REQ-024 On an accepted resolution where the actual next-PC differs from ex_pred_pc, the block SHALL do the following at the next edge:
- set redirect=1.
- set redirect_pc to the actual next-PC.
- increment mispredict_cnt.
REQ-025 redirect SHALL be high for exactly one cycle per mispredict and return to 0 the following cycle.
REQ-026 The block SHALL hold redirect_pc until the next redirect.
REQ-027 branch_cnt SHALL increment by 1 on every accepted resolution with ex_is_cond=1.
REQ-028 branch_cnt and mispredict_cnt SHALL both wrap from 0xFFFFFFFF to 0.
REQ-029 Back-to-back accepted mispredicts are impossible by REQ-020; the minimum redirect spacing SHALL be 2 cycles.
REQ-030 Update latency SHALL be 1 cycle: a counter changed at edge N is visible on predict from edge N onward.

Reset
REQ-031 While rstn=0, the block SHALL asynchronously set the following regardless of clk:
- all counters to 01 (weak-NT).
- redirect=0.
- redirect_pc=0x00000000.
- branch_cnt=0 and mispredict_cnt=0.
REQ-032 Reset asserted mid-operation SHALL drop a pending redirect immediately and discard any in-flight update.
REQ-033 The first edge after rstn rises SHALL behave as a normal operating cycle.

Verification
REQ-034 Reset then fetch_pc=0x1C000000 -> predict=0; branch_cnt=0, mispredict_cnt=0, redirect=0.
REQ-035 Accepted cond resolution, ex_pc=0x1C000010, taken, ex_target=0x1C000100, ex_pred_pc=0x1C000014 -> next cycle:
- redirect=1, redirect_pc=0x1C000100.
- counter[4]=10, so predict=1 for fetch_pc=0x1C000010.
- both stats counters=1.
REQ-036 Same resolution as REQ-035 in the cycle redirect=1 -> ignored: no counter change, no stats change, redirect=0 the cycle after.
REQ-037 Four consecutive (non-redirect-shadowed) correct taken resolutions on one index -> counter saturates at 11; then two not-taken -> 01, predict=0.
REQ-038 Unconditional jump ex_pc=0xFFFFFFFC, ex_target=0x0, ex_pred_pc=0x0 -> no redirect, no counter change, branch_cnt unchanged.
REQ-039 Indices 0 and 64 entries apart (0x1C000000 and 0x1C000100) alias: an update to one changes predict for the other.
REQ-040 Assert rstn=0 asynchronously mid-cycle while redirect=1 -> redirect=0 and stats=0 before the next clock edge.

Source files
------------

// File: rtl/branch_history_update.sv
// ---------------------------------------------------------------------------
// branch_history_update
//
// Direction predictor with resolution-side update and redirect generation.
// A direct-mapped, untagged table of 2-bit saturating counters is read
// combinationally at fetch and trained when a conditional branch resolves
// in EX.  Any resolution whose actual next-PC disagrees with the PC that
// fetch used produces a one-cycle registered redirect.
//
// Ports
//   clk             sole clock, rising edge
//   rstn            asynchronous active-low reset
//   fetch_pc        PC currently in fetch
//   predict         predicted direction for fetch_pc (1 = taken)
//   ex_valid        resolved control-flow instruction present in EX
//   ex_is_cond      EX instruction is a conditional branch (0 = jump)
//   ex_pc           PC of the EX instruction
//   ex_pred_pc      next-PC fetch used for the EX instruction
//   ex_taken        actual direction (treated as 1 for jumps)
//   ex_target       actual taken target
//   redirect        registered one-cycle pulse: restart fetch
//   redirect_pc     correct next-PC, held until the next redirect
//   branch_cnt      accepted conditional resolutions (wraps)
//   mispredict_cnt  issued redirects (wraps)
// ---------------------------------------------------------------------------
module branch_history_update #(
    parameter int IDX_W = 6
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] fetch_pc,
    output logic        predict,
    input  logic        ex_valid,
    input  logic        ex_is_cond,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_pred_pc,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic [31:0] branch_cnt,
    output logic [31:0] mispredict_cnt
);

    localparam int ENTRIES = 1 << IDX_W;

    logic [1:0]       ctr_q [ENTRIES];
    logic [IDX_W-1:0] fetch_idx;
    logic [IDX_W-1:0] ex_idx;
    logic             accept;
    logic             eff_taken;
    logic [31:0]      actual_npc;
    logic             mispredict;
    logic             unused_fetch_bits;

    assign fetch_idx = fetch_pc[IDX_W+1:2];
    assign ex_idx    = ex_pc[IDX_W+1:2];

    // Only the index bits of fetch_pc matter; the table carries no tag.
    assign unused_fetch_bits = ^{fetch_pc[31:IDX_W+2], fetch_pc[1:0]};

    // Read is the registered table value: an update landing at this edge
    // is not forwarded to a same-cycle read.
    assign predict = ctr_q[fetch_idx][1];

    // While a redirect is out, whatever sits in EX is wrong-path.
    assign accept     = ex_valid && !redirect;
    assign eff_taken  = ex_is_cond ? ex_taken : 1'b1;
    assign actual_npc = eff_taken ? ex_target : (ex_pc + 32'd4);
    assign mispredict = accept && (actual_npc != ex_pred_pc);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= 2'b01;
            end
        end else if (accept && ex_is_cond) begin
            if (ex_taken) begin
                if (ctr_q[ex_idx] != 2'b11) begin
                    ctr_q[ex_idx] <= ctr_q[ex_idx] + 2'b01;
                end
            end else begin
                if (ctr_q[ex_idx] != 2'b00) begin
                    ctr_q[ex_idx] <= ctr_q[ex_idx] - 2'b01;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            redirect       <= 1'b0;
            redirect_pc    <= 32'h0000_0000;
            branch_cnt     <= 32'd0;
            mispredict_cnt <= 32'd0;
        end else begin
            // A redirect can never follow itself: the shadow cycle blocks
            // acceptance, so this naturally forms a one-cycle pulse.
            redirect <= mispredict;
            if (mispredict) begin
                redirect_pc    <= actual_npc;
                mispredict_cnt <= mispredict_cnt + 32'd1;
            end
            if (accept && ex_is_cond) begin
                branch_cnt <= branch_cnt + 32'd1;
            end
        end
    end

endmodule
